// File: rtl/bpf_sched_pkg.sv
// Shared types for the BPF core scheduler: per-core state encoding and counter width.
package bpf_sched_pkg;

  typedef enum logic [1:0] {
    CoreIdle = 2'd0,
    CoreRun  = 2'd1,
    CoreDone = 2'd2
  } core_state_e;

  localparam int unsigned BUSY_CNT_W = 5;

endpackage

// File: rtl/bpf_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping past N-1.
module bpf_rr_arb #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  int unsigned     cand;
  logic [IdxW-1:0] cand_idx;

  always_comb begin
    gnt      = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IdxW'(cand);
      if (!any && req[cand_idx]) begin
        any           = 1'b1;
        gnt[cand_idx] = 1'b1;
        idx           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/bpfvm_sched.sv
// Dispatches buffer IDs to idle BPF cores and serialises their RET verdicts into one stream.
module bpfvm_sched
  import bpf_sched_pkg::*;
#(
  parameter int unsigned N_CORES  = 4,
  parameter int unsigned BUF_ID_W = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pkt_valid,
  input  logic [BUF_ID_W-1:0]          pkt_buf_id,
  output logic                         pkt_ready,
  output logic [N_CORES-1:0]           core_start,
  output logic [N_CORES*BUF_ID_W-1:0]  core_buf_id,
  input  logic [N_CORES-1:0]           core_accept,
  input  logic [N_CORES-1:0]           core_reject,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         res_accept,
  output logic [BUF_ID_W-1:0]          res_buf_id,
  output logic [BUSY_CNT_W-1:0]        busy_cnt,
  output logic                         err
);

  localparam int unsigned PtrW = $clog2(N_CORES);

  core_state_e state_q [N_CORES];
  core_state_e state_d [N_CORES];

  logic [N_CORES-1:0][BUF_ID_W-1:0] buf_q;
  logic [N_CORES-1:0] verdict_q;
  logic [PtrW-1:0]    disp_ptr_q, col_ptr_q;
  logic               res_valid_q, res_accept_q, err_q, err_d;
  logic [BUF_ID_W-1:0] res_buf_id_q;

  logic [N_CORES-1:0] idle, done, col_gnt, col_take, disp_req, disp_gnt, disp_take;
  logic [PtrW-1:0]    col_idx, disp_idx;
  logic               col_any, disp_any, load, disp_fire;

  always_comb begin
    for (int i = 0; i < int'(N_CORES); i++) begin
      idle[i] = (state_q[i] == CoreIdle);
      done[i] = (state_q[i] == CoreDone);
    end
  end

  assign load = !res_valid_q || res_ready;

  bpf_rr_arb #(.N(N_CORES)) u_col_arb (
    .req (done),
    .ptr (col_ptr_q),
    .gnt (col_gnt),
    .idx (col_idx),
    .any (col_any)
  );

  assign col_take = col_gnt & {N_CORES{load}};
  // A core being collected this edge is already free for a new dispatch.
  assign disp_req = idle | col_take;

  bpf_rr_arb #(.N(N_CORES)) u_disp_arb (
    .req (disp_req),
    .ptr (disp_ptr_q),
    .gnt (disp_gnt),
    .idx (disp_idx),
    .any (disp_any)
  );

  assign pkt_ready = !rst && disp_any;
  assign disp_fire = pkt_valid && pkt_ready;
  assign disp_take = disp_gnt & {N_CORES{disp_fire}};

  always_comb begin
    err_d = err_q;
    for (int i = 0; i < int'(N_CORES); i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        CoreRun: begin
          if (core_accept[i] || core_reject[i]) state_d[i] = CoreDone;
          if (core_accept[i] && core_reject[i]) err_d = 1'b1;
        end
        CoreDone: begin
          if (col_take[i]) state_d[i] = CoreIdle;
          if (core_accept[i] || core_reject[i]) err_d = 1'b1;
        end
        default: begin
          if (core_accept[i] || core_reject[i]) err_d = 1'b1;
        end
      endcase
      if (disp_take[i]) state_d[i] = CoreRun;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_CORES); i++) state_q[i] <= CoreIdle;
      buf_q        <= '0;
      verdict_q    <= '0;
      disp_ptr_q   <= '0;
      col_ptr_q    <= '0;
      res_valid_q  <= 1'b0;
      res_accept_q <= 1'b0;
      res_buf_id_q <= '0;
      err_q        <= 1'b0;
    end else begin
      for (int i = 0; i < int'(N_CORES); i++) begin
        state_q[i] <= state_d[i];
        if (disp_take[i]) buf_q[i] <= pkt_buf_id;
        if (state_q[i] == CoreRun && (core_accept[i] || core_reject[i])) begin
          verdict_q[i] <= core_accept[i] & ~core_reject[i];
        end
      end
      if (disp_fire) begin
        disp_ptr_q <= (disp_idx == PtrW'(N_CORES - 1)) ? '0 : disp_idx + PtrW'(1);
      end
      if (load) begin
        res_valid_q <= col_any;
        if (col_any) begin
          res_accept_q <= verdict_q[col_idx];
          res_buf_id_q <= buf_q[col_idx];
          col_ptr_q    <= (col_idx == PtrW'(N_CORES - 1)) ? '0 : col_idx + PtrW'(1);
        end
      end
      err_q <= err_d;
    end
  end

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < int'(N_CORES); i++) begin
      core_start[i] = (state_q[i] == CoreRun);
      if (!idle[i]) busy_cnt = busy_cnt + BUSY_CNT_W'(1);
    end
  end

  assign core_buf_id = buf_q;
  assign res_valid   = res_valid_q;
  assign res_accept  = res_accept_q;
  assign res_buf_id  = res_buf_id_q;
  assign err         = err_q;

endmodule
